// File: rtl/mem_access_ctrl_if.sv
// MEM-stage data-memory access bundle.
// Groups the pipeline request side (req_*, ext_stall, flush), the cache port
// (dmem*, dhit, dload), the coherence snoop and the status outputs.
//   slave  : the access controller (mem_access_ctrl)
//   master : the pipeline/cache environment driving it
interface mem_access_ctrl_if;
    localparam int unsigned WordW = 32;
    localparam int unsigned CntW  = 16;

    // Pipeline request (EX/MEM latch outputs)
    logic             req_ren;
    logic             req_wen;
    logic             req_ll;
    logic             req_sc;
    logic [WordW-1:0] req_addr;
    logic [WordW-1:0] req_store;
    logic             ext_stall;
    logic             flush;
    // Cache response and coherence
    logic             dhit;
    logic [WordW-1:0] dload;
    logic             snoop_inv;
    logic [WordW-1:0] snoop_addr;
    // Cache request and pipeline results
    logic             dmemREN;
    logic             dmemWEN;
    logic [WordW-1:0] dmemaddr;
    logic [WordW-1:0] dmemstore;
    logic             mem_stall;
    logic [WordW-1:0] load_data;
    logic [CntW-1:0]  stall_cycles;

    modport slave (
        input  req_ren, req_wen, req_ll, req_sc, req_addr, req_store,
        input  ext_stall, flush, dhit, dload, snoop_inv, snoop_addr,
        output dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
        output load_data, stall_cycles
    );

    modport master (
        output req_ren, req_wen, req_ll, req_sc, req_addr, req_store,
        output ext_stall, flush, dhit, dload, snoop_inv, snoop_addr,
        input  dmemREN, dmemWEN, dmemaddr, dmemstore, mem_stall,
        input  load_data, stall_cycles
    );
endinterface

// File: rtl/mem_access_ctrl.sv
// MEM-stage data-memory access sequencer.
// Issues one cache access per MEM-stage instruction, raises mem_stall while
// the access is outstanding, holds a completed result while the pipeline is
// frozen by another hazard, and owns the LL/SC link register.
// Ports:
//   CLK  : rising-edge clock
//   RST  : synchronous active-high reset
//   bus  : mem_access_ctrl_if.slave (request, cache port, snoop, status)
module mem_access_ctrl (
    input  logic              CLK,
    input  logic              RST,
    mem_access_ctrl_if.slave  bus
);
    localparam int unsigned WordW = 32;
    localparam int unsigned LinkW = 30;
    localparam int unsigned CntW  = 16;

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t           state;
    state_t           stateNext;
    logic [WordW-1:0] holdReg;
    logic [WordW-1:0] holdNext;
    logic             linkValid;
    logic [LinkW-1:0] linkAddr;
    logic [CntW-1:0]  stallCnt;

    logic             scOk;
    logic             wenEff;
    logic             act;
    logic             stallC;
    logic [WordW-1:0] result;
    logic             complete;
    logic             llSet;
    logic             linkClr;
    logic [LinkW-1:0] snoopCmp;

    // Request qualification: a failing SC never reaches the cache, a flushed read is dropped
    assign scOk   = linkValid && (linkAddr == bus.req_addr[31:2]);
    assign wenEff = bus.req_wen & ~(bus.req_sc & ~scOk);
    assign act    = (bus.req_ren | wenEff) & ~(bus.flush & bus.req_ren);

    // Value handed to the MEM/WB latch when no held result is pending
    always_comb begin
        result = '0;
        if (bus.req_ren)
            result = bus.dload;
        else if (bus.req_wen && bus.req_sc && scOk)
            result = WordW'(1);
    end

    // Next-state and cache-port outputs
    always_comb begin
        stateNext     = state;
        holdNext      = holdReg;
        bus.dmemREN   = 1'b0;
        bus.dmemWEN   = 1'b0;
        stallC        = 1'b0;
        bus.load_data = result;
        case (state)
            IDLE, ACCESS: begin
                bus.dmemREN = act & bus.req_ren;
                bus.dmemWEN = act & wenEff;
                stallC      = act & ~bus.dhit;
                if (act && !bus.dhit) begin
                    stateNext = ACCESS;
                end else if (act && bus.dhit && bus.ext_stall) begin
                    // Access finished but the latch is frozen: keep the result, never re-issue
                    stateNext = DONE;
                    holdNext  = result;
                end else begin
                    stateNext = IDLE;
                end
            end
            DONE: begin
                bus.load_data = holdReg;
                if (!bus.ext_stall || (bus.flush && bus.req_ren))
                    stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.mem_stall    = stallC;
    assign bus.dmemaddr     = bus.req_addr;
    assign bus.dmemstore    = bus.req_store;
    assign bus.stall_cycles = stallCnt;

    // Link register events; a snoop in the LL completion cycle is compared to the new address
    assign complete = (state != DONE) & act & bus.dhit;
    assign llSet    = complete & bus.req_ren & bus.req_ll;
    assign snoopCmp = llSet ? bus.req_addr[31:2] : linkAddr;
    assign linkClr  = (bus.req_wen & bus.req_sc & (state != DONE) & (~scOk | complete))
                    | (complete & wenEff & (bus.req_addr[31:2] == linkAddr))
                    | (bus.snoop_inv & (bus.snoop_addr[31:2] == snoopCmp));

    // State, held result, link and stall counter registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            holdReg   <= '0;
            linkValid <= 1'b0;
            linkAddr  <= '0;
            stallCnt  <= '0;
        end else begin
            state     <= stateNext;
            holdReg   <= holdNext;
            if (llSet)
                linkAddr <= bus.req_addr[31:2];
            linkValid <= (linkValid | llSet) & ~linkClr;
            if (stallC && (stallCnt != {CntW{1'b1}}))
                stallCnt <= stallCnt + CntW'(1);
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed scenarios with literal
// expectations, then pipeline-like random traffic against a behavioural model.
module tb_mem_access_ctrl;
    logic clk = 1'b0;
    logic rst;

    mem_access_ctrl_if bus();

    mem_access_ctrl dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errs    = 0;

    // Behavioural model: frozen-result flag, link, stall count
    bit          mHeld;
    logic [31:0] mHeldVal;
    bit          mLinkV;
    logic [29:0] mLinkA;
    int          mStall;
    bit          lastHold;

    logic [31:0] pool [4] = '{32'h40, 32'h44, 32'h80, 32'h1000};

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic setIdle();
        bus.req_ren    = 1'b0;
        bus.req_wen    = 1'b0;
        bus.req_ll     = 1'b0;
        bus.req_sc     = 1'b0;
        bus.req_addr   = '0;
        bus.req_store  = '0;
        bus.ext_stall  = 1'b0;
        bus.flush      = 1'b0;
        bus.dhit       = 1'b0;
        bus.dload      = '0;
        bus.snoop_inv  = 1'b0;
        bus.snoop_addr = '0;
    endtask

    task automatic setReq(input int kind, input logic [31:0] addr);
        bus.req_ren  = (kind == 1) || (kind == 2);
        bus.req_ll   = (kind == 2);
        bus.req_wen  = (kind == 3) || (kind == 4);
        bus.req_sc   = (kind == 4);
        bus.req_addr = addr;
    endtask

    // Compare the DUT against the model for the current inputs, then advance one clock
    task automatic tick();
        bit scOk, rdLive, wrLive, fin, setL, clrL, expStall, nHeld;
        logic [31:0] res, expLoad;
        logic [29:0] cmpA;
        if (rst) begin
            @(posedge clk);
            mHeld = 0; mHeldVal = '0; mLinkV = 0; mLinkA = '0; mStall = 0; lastHold = 0;
            @(negedge clk);
            return;
        end
        scOk   = mLinkV && (mLinkA == bus.req_addr[31:2]);
        rdLive = !mHeld && bus.req_ren && !bus.flush;
        wrLive = !mHeld && bus.req_wen && (!bus.req_sc || scOk);
        if (bus.req_ren)                                res = bus.dload;
        else if (bus.req_wen && bus.req_sc && scOk)     res = 32'd1;
        else                                            res = 32'd0;
        expStall = (rdLive || wrLive) && !bus.dhit;
        expLoad  = mHeld ? mHeldVal : res;

        chk1 ("dmemREN",   bus.dmemREN,   rdLive);
        chk1 ("dmemWEN",   bus.dmemWEN,   wrLive);
        chk1 ("mem_stall", bus.mem_stall, expStall);
        chk32("load_data", bus.load_data, expLoad);
        chk32("dmemaddr",  bus.dmemaddr,  bus.req_addr);
        chk32("dmemstore", bus.dmemstore, bus.req_store);
        chk32("stall_cycles", 32'(bus.stall_cycles), 32'(mStall));

        if (mHeld) nHeld = bus.ext_stall && !(bus.flush && bus.req_ren);
        else       nHeld = (rdLive || wrLive) && bus.dhit && bus.ext_stall;

        fin  = (rdLive || wrLive) && bus.dhit;
        setL = fin && bus.req_ren && bus.req_ll;
        cmpA = setL ? bus.req_addr[31:2] : mLinkA;
        clrL = (!mHeld && bus.req_wen && bus.req_sc && (!scOk || fin))
            || (fin && bus.req_wen && (bus.req_addr[31:2] == mLinkA))
            || (bus.snoop_inv && (bus.snoop_addr[31:2] == cmpA));
        lastHold = expStall || bus.ext_stall;

        @(posedge clk);
        if (!mHeld && nHeld) mHeldVal = res;
        mHeld  = nHeld;
        if (setL) mLinkA = bus.req_addr[31:2];
        mLinkV = (mLinkV || setL) && !clrL;
        if (expStall && mStall < 65535) mStall++;
        @(negedge clk);
    endtask

    task automatic step();
        #1;
        tick();
    endtask

    initial begin
        setIdle();
        rst = 1'b1;
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        // Reset state with idle inputs
        #1;
        chk1 ("rst_ren",   bus.dmemREN,   1'b0);
        chk1 ("rst_wen",   bus.dmemWEN,   1'b0);
        chk1 ("rst_stall", bus.mem_stall, 1'b0);
        chk32("rst_cnt",   32'(bus.stall_cycles), 32'd0);
        tick();

        // Read hit, zero wait
        setReq(1, 32'h100); bus.dhit = 1'b1; bus.dload = 32'hDEADBEEF;
        #1;
        chk1 ("rdhit_ren",   bus.dmemREN,   1'b1);
        chk1 ("rdhit_stall", bus.mem_stall, 1'b0);
        chk32("rdhit_load",  bus.load_data, 32'hDEADBEEF);
        tick();
        setIdle(); step();

        // Write miss, dhit three cycles later
        setReq(3, 32'h200); bus.req_store = 32'h12345678;
        for (int i = 0; i < 4; i++) begin
            bus.dhit = (i == 3);
            #1;
            chk1("wrmiss_wen",   bus.dmemWEN,   1'b1);
            chk1("wrmiss_stall", bus.mem_stall, i != 3);
            tick();
        end
        setIdle();
        #1;
        chk32("wrmiss_cnt", 32'(bus.stall_cycles), 32'd3);
        tick();

        // Completion while another hazard freezes the latch
        setReq(1, 32'h300); bus.dhit = 1'b1; bus.dload = 32'hCAFEF00D; bus.ext_stall = 1'b1;
        step();
        bus.dhit = 1'b0; bus.dload = 32'h0;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk1 ("frz_ren",  bus.dmemREN,   1'b0);
            chk1 ("frz_stall",bus.mem_stall, 1'b0);
            chk32("frz_load", bus.load_data, 32'hCAFEF00D);
            tick();
        end
        bus.ext_stall = 1'b0;
        step();
        setIdle(); bus.req_ren = 1'b1; bus.dhit = 1'b0;
        #1;
        chk1("frz_reissue", bus.dmemREN, 1'b1);
        tick();
        setIdle(); bus.dhit = 1'b0; step();

        // LL/SC success, then repeated SC fails
        setReq(2, 32'h40); bus.dhit = 1'b1; step();
        setReq(4, 32'h40); bus.dhit = 1'b1;
        #1;
        chk1 ("sc1_wen",  bus.dmemWEN,   1'b1);
        chk32("sc1_load", bus.load_data, 32'd1);
        tick();
        setReq(4, 32'h40); bus.dhit = 1'b0;
        #1;
        chk1 ("sc2_wen",   bus.dmemWEN,   1'b0);
        chk1 ("sc2_stall", bus.mem_stall, 1'b0);
        chk32("sc2_load",  bus.load_data, 32'd0);
        tick();
        setIdle(); step();

        // Snoop to a neighbouring word keeps the link
        setReq(2, 32'h40); bus.dhit = 1'b1; step();
        setIdle(); bus.snoop_inv = 1'b1; bus.snoop_addr = 32'h44; step();
        setIdle(); setReq(4, 32'h40); bus.dhit = 1'b1;
        #1;
        chk32("snpnb_load", bus.load_data, 32'd1);
        tick();

        // Snoop to the linked word breaks it
        setReq(2, 32'h40); bus.dhit = 1'b1; step();
        setIdle(); bus.snoop_inv = 1'b1; bus.snoop_addr = 32'h44; step();
        setIdle(); bus.snoop_inv = 1'b1; bus.snoop_addr = 32'h40; step();
        setIdle(); setReq(4, 32'h40); bus.dhit = 1'b1;
        #1;
        chk1 ("snp_wen",  bus.dmemWEN,   1'b0);
        chk32("snp_load", bus.load_data, 32'd0);
        tick();

        // Snoop in the LL completion cycle
        setIdle(); setReq(2, 32'h80); bus.dhit = 1'b1;
        bus.snoop_inv = 1'b1; bus.snoop_addr = 32'h80; step();
        setIdle(); setReq(4, 32'h80); bus.dhit = 1'b1;
        #1;
        chk1("snpll_wen", bus.dmemWEN, 1'b0);
        tick();

        // Flush aborts a read miss
        setIdle(); setReq(1, 32'h500); step();
        bus.flush = 1'b1;
        #1;
        chk1("flrd_ren",   bus.dmemREN,   1'b0);
        chk1("flrd_stall", bus.mem_stall, 1'b0);
        tick();

        // Flush does not abort a write miss
        setIdle(); setReq(3, 32'h600); bus.flush = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.dhit = (i == 2);
            #1;
            chk1("flwr_wen",   bus.dmemWEN,   1'b1);
            chk1("flwr_stall", bus.mem_stall, i != 2);
            tick();
        end

        // Reset while an access is outstanding
        setIdle(); setReq(1, 32'h700); step(); step();
        rst = 1'b1; step();
        rst = 1'b0; setIdle();
        #1;
        chk1 ("rstm_ren",   bus.dmemREN,   1'b0);
        chk1 ("rstm_stall", bus.mem_stall, 1'b0);
        chk32("rstm_load",  bus.load_data, 32'd0);
        chk32("rstm_cnt",   32'(bus.stall_cycles), 32'd0);
        tick();

        // Random pipeline traffic: request fields change only when the pipeline advances
        for (int n = 0; n < 3000; n++) begin
            if (!lastHold) begin
                setReq(int'($urandom_range(0, 4)),
                       pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3)));
                bus.req_store = $urandom;
            end
            bus.ext_stall  = ($urandom_range(0, 3) == 0);
            bus.flush      = ($urandom_range(0, 9) == 0);
            bus.dhit       = ($urandom_range(0, 9) < 4);
            bus.dload      = $urandom;
            bus.snoop_inv  = ($urandom_range(0, 6) == 0);
            bus.snoop_addr = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 3));
            rst            = ($urandom_range(0, 199) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Sequencer for the data-memory access made by the MEM pipeline stage. It sits between the EX/MEM latch outputs (request, address, store data) and the data cache port. It issues exactly one cache access per MEM-stage instruction, generates the MEM stall, and holds a completed result if the pipeline is frozen by another hazard. It also owns the LL/SC link register.

## Interface
- No parameters; all widths fixed (word_t = 32 bits).
- CLK  in  1  system clock, rising-edge.
- RST  in  1  synchronous, active-high reset.
- req_ren  in  1  MEM-stage instruction reads memory (LW, LL).
- req_wen  in  1  MEM-stage instruction writes memory (SW, SC); never high together with req_ren.
- req_ll  in  1  qualifies req_ren as LL.
- req_sc  in  1  qualifies req_wen as SC.
- req_addr  in  32  byte address (ALU result).
- req_store  in  32  store data (busB).
- ext_stall  in  1  pipeline latches frozen by another hazard this cycle.
- flush  in  1  MEM-stage instruction squashed.
- dhit  in  1  cache completed the access this cycle.
- dload  in  32  cache read data, valid with dhit.
- snoop_inv  in  1  coherence invalidate this cycle.
- snoop_addr  in  32  invalidated address.
- dmemREN  out  1  cache read request.
- dmemWEN  out  1  cache write request.
- dmemaddr  out  32  cache address (= req_addr).
- dmemstore  out  32  cache write data (= req_store).
- mem_stall  out  1  hold the whole pipeline.
- load_data  out  32  value for the MEM/WB latch dmemload input.
- stall_cycles  out  16  saturating count of mem_stall cycles.

## Operation
- States: IDLE, ACCESS, DONE. Reset -> IDLE.
- Request active: act = (req_ren | wen_eff) & ~(flush & req_ren). wen_eff = req_wen & ~(req_sc & ~sc_ok).
- sc_ok = link_valid & (link_addr == req_addr[31:2]).
- IDLE/ACCESS behaviour:
  - dmemREN = act & req_ren.
  - dmemWEN = act & wen_eff.
  - mem_stall = act & ~dhit.
  - act & ~dhit: go to ACCESS.
  - act & dhit & ext_stall: capture result into hold_reg and go to DONE.
  - act & dhit & ~ext_stall: go to IDLE.
  - ~act: go to IDLE.
- DONE behaviour:
  - dmemREN = dmemWEN = 0; mem_stall = 0; load_data = hold_reg.
  - Leave to IDLE when ~ext_stall, or when flush is asserted with a held read.
- Result selection (outside DONE):
  - Read: dload.
  - SC with sc_ok: 32'd1.
  - SC without sc_ok: 32'd0, issues no cache access and no stall.
  - Other cases: 32'd0.
- Flush rules:
  - Flush aborts a read at once (REN drops that cycle, state -> IDLE).
  - Flush is ignored for writes: a store in progress always completes.
- Link register (link_valid, link_addr[29:0]):
  - Set on LL completion (read with dhit).
  - Cleared on SC completion, regardless of outcome.
  - Cleared by a completed SW/SC whose address matches link_addr.
  - Cleared by snoop_inv whose snoop_addr[31:2] matches link_addr.
  - If set and clear happen in the same cycle, clear wins.
- stall_cycles increments every cycle mem_stall = 1 and saturates at 16'hFFFF.

## Timing
- Reset values:
  - state = IDLE, hold_reg = 0, link_valid = 0, link_addr = 0, stall_cycles = 0.
  - All request outputs are 0 while inputs are idle.
- dmemREN, dmemWEN, mem_stall and load_data are combinational from the current state and inputs. All state changes occur on the CLK edge.
- Zero-wait hit: the access completes in the request cycle with no stall.
- N-cycle miss: mem_stall is high for exactly N cycles; the request is held on the port until dhit.
- Each instruction makes exactly one cache transaction. After dhit, the access is never re-issued while ext_stall holds the latch (DONE).
- RST in any state returns to IDLE in the next cycle and clears the link; an outstanding request is dropped.
- Address compare uses word address bits [31:2] only.

## Test plan
- Read hit: req_ren with addr 0x100 and dhit in the same cycle, dload = 0xDEADBEEF -> no stall, load_data = 0xDEADBEEF, state stays IDLE.
- Write miss: req_wen with addr 0x200, dhit 3 cycles later -> dmemWEN held 4 cycles, mem_stall high 3 cycles, stall_cycles = 3.
- Completion under ext_stall: read with dhit while ext_stall = 1 for 2 more cycles -> dmemREN = 0 in those 2 cycles, load_data holds the captured dload, return to IDLE when ext_stall drops.
- LL/SC success: LL at 0x40, then SC at 0x40 -> SC issues WEN, load_data = 1, link cleared. A second SC at 0x40 -> no WEN, no stall, load_data = 0.
- LL/SC break: LL at 0x40, then snoop_inv at 0x44 (link survives), then snoop_inv at 0x40 -> following SC returns 0 with no cache access. Also: snoop in the same cycle as LL dhit -> link invalid.
- Flush/reset: flush during a read miss -> REN drops that cycle, no stall. Flush during a write miss -> WEN held until dhit. RST mid-ACCESS -> IDLE, all outputs 0, stall_cycles = 0.
